// File: rtl/usb_upstream_arbiter_if.sv
// -----------------------------------------------------------------------------
// usb_upstream_arbiter_if
//   Bundles the producer-FIFO side and the bridge side of the upstream
//   arbiter into one interface.
//
//   master : the arbiter (drives in_pop, out_nempty, out_data, busy, cur_chan)
//   slave  : the environment (producer FIFOs, channel enables and the bridge)
//
//   chan_en    [CHANNELS]    per-channel enable
//   in_nempty  [CHANNELS]    per-channel FWFT FIFO not-empty
//   in_level   [16*CHANNELS] per-channel fill level, channel i at [16i+15:16i]
//   in_data    [32*CHANNELS] per-channel head word, channel i at [32i+31:32i]
//   in_pop     [CHANNELS]    per-channel pop
//   out_nempty               word available to the bridge
//   out_data   [32]          word presented to the bridge
//   out_pop                  bridge consumes out_data this cycle
//   busy                     packet in progress (HEADER or DATA)
//   cur_chan   [4]           currently granted channel
// -----------------------------------------------------------------------------
interface usb_upstream_arbiter_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]    chan_en;
    logic [CHANNELS-1:0]    in_nempty;
    logic [16*CHANNELS-1:0] in_level;
    logic [32*CHANNELS-1:0] in_data;
    logic [CHANNELS-1:0]    in_pop;
    logic                   out_nempty;
    logic [31:0]            out_data;
    logic                   out_pop;
    logic                   busy;
    logic [3:0]             cur_chan;

    modport master (
        input  chan_en, in_nempty, in_level, in_data, out_pop,
        output in_pop, out_nempty, out_data, busy, cur_chan
    );

    modport slave (
        output chan_en, in_nempty, in_level, in_data, out_pop,
        input  in_pop, out_nempty, out_data, busy, cur_chan
    );
endinterface

// File: rtl/usb_upstream_arbiter.sv
// -----------------------------------------------------------------------------
// usb_upstream_arbiter
//   Round-robin scheduler sharing the single upstream word path of the USB
//   FIFO bridge between CHANNELS producer FIFOs. Each grant is sent as one
//   packet: a header {MAGIC, channel, length} followed by exactly `length`
//   data words popped from the granted channel.
//
//   clk    : USB FIFO clock (same as the bridge)
//   rst_n  : asynchronous active-low reset
//   bus    : usb_upstream_arbiter_if.master (FIFO side, bridge side, status)
// -----------------------------------------------------------------------------
module usb_upstream_arbiter #(
    parameter int          CHANNELS  = 4,
    parameter int          MAX_BURST = 256,
    parameter logic [15:0] MAGIC     = 16'hA55A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    usb_upstream_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  rr_ptr;
    logic [3:0]  sel;
    logic [11:0] len;
    logic [11:0] remaining;

    logic [CHANNELS-1:0]   elig;
    logic [2*CHANNELS-1:0] rot;
    logic                  found;
    logic [3:0]            off;
    logic [4:0]            win_sum;
    logic [3:0]            win;
    logic [15:0]           win_level;
    logic [11:0]           win_len;

    logic        sel_nempty;
    logic [31:0] sel_data;
    logic        data_pop;

    // Grant search: rotate the eligible vector so rr_ptr lands on bit 0, take
    // the lowest set bit, then rotate the offset back into a channel number.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        elig = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            elig[i] = bus.chan_en[i] && (bus.in_level[16*i +: 16] != 16'd0);
        end
        rot   = {elig, elig} >> rr_ptr;
        found = |rot[CHANNELS-1:0];
        off   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot[k]) off = 4'(k);
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, off};
        win     = (win_sum >= 5'(CHANNELS)) ? 4'(win_sum - 5'(CHANNELS)) : win_sum[3:0];

        win_level = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (win == 4'(i)) win_level = bus.in_level[16*i +: 16];
        end
        win_len = (win_level > 16'(MAX_BURST)) ? 12'(MAX_BURST) : win_level[11:0];
    end

    // Head-of-FIFO view of the granted channel.
    always_comb begin
        sel_nempty = 1'b0;
        sel_data   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == 4'(i)) begin
                sel_nempty = bus.in_nempty[i];
                sel_data   = bus.in_data[32*i +: 32];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and the combinational word/pop path.
    always_comb begin
        state_nxt      = state;
        bus.out_nempty = 1'b0;
        bus.out_data   = '0;
        bus.in_pop     = '0;
        data_pop       = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_nxt = HEADER;
            end
            HEADER: begin
                bus.out_nempty = 1'b1;
                bus.out_data   = {MAGIC, sel, len};
                if (bus.out_pop) state_nxt = DATA;
            end
            DATA: begin
                bus.out_nempty = sel_nempty;
                bus.out_data   = sel_data;
                // A pop with the selected FIFO empty is ignored: nothing moves.
                data_pop = bus.out_pop && sel_nempty;
                for (int i = 0; i < CHANNELS; i++) begin
                    bus.in_pop[i] = data_pop && (sel == 4'(i));
                end
                if (data_pop && remaining == 12'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, length and round-robin bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            sel       <= '0;
            len       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel <= win;
                        len <= win_len;
                    end
                end
                HEADER: begin
                    if (bus.out_pop) remaining <= len;
                end
                DATA: begin
                    if (data_pop) begin
                        remaining <= remaining - 12'd1;
                        // The granted channel yields after every packet.
                        if (remaining == 12'd1) begin
                            rr_ptr <= (sel == 4'(CHANNELS - 1)) ? 4'd0 : sel + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.cur_chan = sel;

endmodule

// File: tb/tb_usb_upstream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_upstream_arbiter
//   Directed bench for usb_upstream_arbiter. Two instances share clock and
//   reset: `dut` (MAX_BURST = 256) behind FIFO models in `fifo`, and `dut_c`
//   (MAX_BURST = 4) fed by a single counted source on channel 1.
//   Inputs change 1 ns after the rising edge; outputs are checked 2+ ns after.
// -----------------------------------------------------------------------------
module tb_usb_upstream_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_upstream_arbiter_if #(.CHANNELS(4)) bus ();
    usb_upstream_arbiter_if #(.CHANNELS(4)) cbus ();

    usb_upstream_arbiter #(.CHANNELS(4), .MAX_BURST(256), .MAGIC(16'hA55A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    usb_upstream_arbiter #(.CHANNELS(4), .MAX_BURST(4), .MAGIC(16'hA55A)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cbus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] fifo [4][$];
    logic [3:0]  stall;
    int          ccnt;
    logic [31:0] got [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present the FIFO models to both instances, then let outputs settle.
    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            bus.in_level[16*i +: 16] = 16'(fifo[i].size());
            bus.in_nempty[i]         = (fifo[i].size() != 0) && !stall[i];
            bus.in_data[32*i +: 32]  = (fifo[i].size() != 0) ? fifo[i][0] : 32'h0;
        end
        cbus.in_level          = '0;
        cbus.in_nempty         = '0;
        cbus.in_data           = '0;
        cbus.in_level[31:16]   = 16'(ccnt);
        cbus.in_nempty[1]      = (ccnt != 0);
        cbus.in_data[63:32]    = 32'hC00 + 32'(10 - ccnt);
        #1;
    endtask

    // Advance one clock: retire popped FIFO words and log accepted words.
    task automatic tick();
        logic [3:0]  p;
        logic        cp;
        logic        take;
        logic [31:0] w;
        p    = bus.in_pop;
        cp   = cbus.in_pop[1];
        take = bus.out_nempty && bus.out_pop;
        w    = bus.out_data;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (p[i] && fifo[i].size() != 0) fifo[i].delete(0);
        end
        if (cp && ccnt > 0) ccnt--;
        if (take) got.push_back(w);
        #1;
        apply();
    endtask

    task automatic expect_word(input string tag, input bit c, input logic [31:0] exp);
        check({tag, "_ne"}, c ? 32'(cbus.out_nempty) : 32'(bus.out_nempty), 32'd1);
        check(tag, c ? cbus.out_data : bus.out_data, exp);
        tick();
    endtask

    task automatic expect_gap(input string tag, input bit c);
        check({tag, "_ne"}, c ? 32'(cbus.out_nempty) : 32'(bus.out_nempty), 32'd0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pop;

        stall        = '0;
        ccnt         = 0;
        bus.chan_en  = 4'hF;
        bus.out_pop  = 1'b0;
        cbus.chan_en = 4'h0;
        cbus.out_pop = 1'b0;
        apply();

        // Reset values.
        check("rst_out_nempty", 32'(bus.out_nempty), 32'd0);
        check("rst_in_pop",     32'(bus.in_pop),     32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_cur_chan",   32'(bus.cur_chan),   32'd0);
        check("rst_out_data",   bus.out_data,        32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Clamp: level 10 with MAX_BURST 4 gives packets of 4, 4, 2.
        ccnt         = 10;
        cbus.chan_en = 4'b0010;
        cbus.out_pop = 1'b1;
        apply();
        expect_gap("clamp_idle", 1);
        expect_word("clamp_hdr0", 1, 32'hA55A_1004);
        for (int k = 0; k < 4; k++) expect_word("clamp_d0", 1, 32'hC00 + 32'(k));
        expect_gap("clamp_gap0", 1);
        expect_word("clamp_hdr1", 1, 32'hA55A_1004);
        for (int k = 4; k < 8; k++) expect_word("clamp_d1", 1, 32'hC00 + 32'(k));
        expect_gap("clamp_gap1", 1);
        expect_word("clamp_hdr2", 1, 32'hA55A_1002);
        expect_word("clamp_d2a", 1, 32'hC08);
        expect_word("clamp_d2b", 1, 32'hC09);
        expect_gap("clamp_gap2", 1);
        check("clamp_drained", 32'(ccnt), 32'd0);
        cbus.chan_en = 4'h0;
        cbus.out_pop = 1'b0;

        // Single packet on channel 2, then the one-cycle gap and channel 3.
        for (int k = 0; k < 3; k++) fifo[2].push_back(32'h100 + 32'(k));
        fifo[3].push_back(32'h300);
        bus.out_pop = 1'b1;
        apply();
        expect_gap("t1_idle", 0);
        check("t1_busy_hdr", 32'(bus.busy), 32'd1);
        check("t1_cur_chan", 32'(bus.cur_chan), 32'd2);
        expect_word("t1_hdr", 0, 32'hA55A_2003);
        check("t1_in_pop", 32'(bus.in_pop), 32'b0100);
        expect_word("t1_d0", 0, 32'h100);
        expect_word("t1_d1", 0, 32'h101);
        expect_word("t1_d2", 0, 32'h102);
        check("t1_gap_busy",   32'(bus.busy),   32'd0);
        check("t1_gap_in_pop", 32'(bus.in_pop), 32'd0);
        check("t1_rr_ptr",     32'(dut.rr_ptr), 32'd3);
        expect_gap("t1_gap", 0);
        expect_word("t1_hdr3", 0, 32'hA55A_3001);
        expect_word("t1_d3", 0, 32'h300);
        expect_gap("t1_gap3", 0);

        // Round robin 0,1,2,3; channel 0 refilled during channel 1's packet.
        for (int i = 0; i < 4; i++) fifo[i].push_back(32'h200 + 32'(i));
        apply();
        expect_gap("rr_idle", 0);
        expect_word("rr_hdr0", 0, 32'hA55A_0001);
        expect_word("rr_d0", 0, 32'h200);
        expect_gap("rr_gap0", 0);
        fifo[0].push_back(32'h210);
        apply();
        expect_word("rr_hdr1", 0, 32'hA55A_1001);
        expect_word("rr_d1", 0, 32'h201);
        expect_gap("rr_gap1", 0);
        expect_word("rr_hdr2", 0, 32'hA55A_2001);
        expect_word("rr_d2", 0, 32'h202);
        expect_gap("rr_gap2", 0);
        expect_word("rr_hdr3", 0, 32'hA55A_3001);
        expect_word("rr_d3", 0, 32'h203);
        expect_gap("rr_gap3", 0);
        expect_word("rr_hdr0b", 0, 32'hA55A_0001);
        expect_word("rr_d0b", 0, 32'h210);
        expect_gap("rr_gap0b", 0);

        // Backpressure: random out_pop over a 5-word packet on channel 1.
        for (int k = 0; k < 5; k++) fifo[1].push_back(32'h400 + 32'(k));
        got.delete();
        for (int c = 0; c < 200 && got.size() < 6; c++) begin
            bus.out_pop = 1'($urandom_range(0, 1));
            apply();
            exp_pop = (bus.out_pop && got.size() >= 1 && got.size() <= 5) ? 32'b0010 : 32'd0;
            check("bp_in_pop", 32'(bus.in_pop), exp_pop);
            tick();
        end
        check("bp_count", 32'(got.size()), 32'd6);
        check("bp_hdr", got[0], 32'hA55A_1005);
        for (int k = 1; k < 6; k++) check("bp_data", got[k], 32'h400 + 32'(k - 1));
        bus.out_pop = 1'b1;
        apply();
        tick();
        tick();
        check("bp_no_extra", 32'(got.size()), 32'd6);

        // Enable cleared and FIFO stalled mid-packet on channel 0.
        for (int k = 0; k < 6; k++) fifo[0].push_back(32'h500 + 32'(k));
        apply();
        expect_gap("en_idle", 0);
        expect_word("en_hdr", 0, 32'hA55A_0006);
        expect_word("en_d0", 0, 32'h500);
        expect_word("en_d1", 0, 32'h501);
        bus.chan_en[0] = 1'b0;
        fifo[0].push_back(32'h5F0);
        fifo[0].push_back(32'h5F1);
        stall[0] = 1'b1;
        apply();
        for (int c = 0; c < 3; c++) begin
            check("stall_ne",     32'(bus.out_nempty), 32'd0);
            check("stall_in_pop", 32'(bus.in_pop),     32'd0);
            check("stall_busy",   32'(bus.busy),       32'd1);
            tick();
        end
        stall[0] = 1'b0;
        apply();
        for (int k = 2; k < 6; k++) expect_word("en_d", 0, 32'h500 + 32'(k));
        for (int c = 0; c < 3; c++) begin
            check("en_off_busy", 32'(bus.busy), 32'd0);
            expect_gap("en_off_gap", 0);
        end
        fifo[3].push_back(32'h530);
        apply();
        expect_gap("en_idle3", 0);
        expect_word("en_hdr3", 0, 32'hA55A_3001);
        expect_word("en_d3", 0, 32'h530);
        expect_gap("en_gap3", 0);

        // Channel 2 packet with channel 0 still disabled (rr_ptr ends at 3).
        fifo[2].push_back(32'h620);
        apply();
        expect_gap("rs_idle", 0);
        expect_word("rs_hdr2", 0, 32'hA55A_2001);
        expect_word("rs_d2", 0, 32'h620);
        bus.chan_en = 4'hF;
        fifo[3].push_back(32'h631);
        apply();
        expect_gap("rs_gap2", 0);
        expect_word("rs_hdr3", 0, 32'hA55A_3001);
        check("rs_in_pop", 32'(bus.in_pop), 32'b1000);

        // Asynchronous reset in DATA, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rs_async_in_pop", 32'(bus.in_pop),     32'd0);
        check("rs_async_ne",     32'(bus.out_nempty), 32'd0);
        check("rs_async_busy",   32'(bus.busy),       32'd0);
        check("rs_async_chan",   32'(bus.cur_chan),   32'd0);
        check("rs_async_data",   bus.out_data,        32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        apply();
        expect_gap("rs_post_idle", 0);
        expect_word("rs_post_hdr0", 0, 32'hA55A_0002);
        expect_word("rs_post_d0", 0, 32'h5F0);
        expect_word("rs_post_d1", 0, 32'h5F1);
        expect_gap("rs_post_gap0", 0);
        expect_word("rs_post_hdr3", 0, 32'hA55A_3001);
        expect_word("rs_post_d3", 0, 32'h631);
        expect_gap("rs_post_gap3", 0);
        check("drain", 32'(fifo[0].size() + fifo[1].size() + fifo[2].size() + fifo[3].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
